// File: rtl/regfile_oe.sv
// Multi-entry register bank: one write port, two registered read ports with
// individual output enables, write-to-read bypass and a sequential flush FSM.
module regfile_oe #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter bit          ZERO_REG   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  OE_a_i,
    input  logic [ADDR_WIDTH-1:0] raddr_a_i,
    output logic [DATA_WIDTH-1:0] data_a_o,
    input  logic                  OE_b_i,
    input  logic [ADDR_WIDTH-1:0] raddr_b_i,
    output logic [DATA_WIDTH-1:0] data_b_o,
    input  logic                  clear_i,
    output logic                  busy_o
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [0:0]            state;
    logic [0:0]            state_next;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [ADDR_WIDTH-1:0] cnt_next;

    logic                  wr_acc_c;
    logic [DATA_WIDTH-1:0] rd_a_c;
    logic [DATA_WIDTH-1:0] rd_b_c;

    // A write lands only in IDLE and never on the hardwired zero entry.
    assign wr_acc_c = we_i && (state == S_IDLE) && !(ZERO_REG && (waddr_i == '0));

    // State and flush counter registers.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state  <= S_IDLE;
            cnt    <= '0;
            busy_o <= 1'b0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            busy_o <= (state_next == S_CLEAR);
        end
    end

    // Next-state logic: flush walks the counter across every entry once.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            S_IDLE: begin
                if (clear_i) begin
                    state_next = S_CLEAR;
                    cnt_next   = '0;
                end
            end
            S_CLEAR: begin
                cnt_next = cnt + ADDR_WIDTH'(1);
                if (cnt == ADDR_WIDTH'(DEPTH - 1)) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Storage: writes and flush are mutually exclusive by state.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (wr_acc_c) begin
            mem[waddr_i] <= wdata_i;
        end else if (state == S_CLEAR) begin
            mem[cnt] <= '0;
        end
    end

    // Read value selection with zero-entry override and same-edge bypass.
    always_comb begin
        rd_a_c = mem[raddr_a_i];
        if (ZERO_REG && (raddr_a_i == '0)) begin
            rd_a_c = '0;
        end else if (wr_acc_c && (waddr_i == raddr_a_i)) begin
            rd_a_c = wdata_i;
        end
    end

    always_comb begin
        rd_b_c = mem[raddr_b_i];
        if (ZERO_REG && (raddr_b_i == '0)) begin
            rd_b_c = '0;
        end else if (wr_acc_c && (waddr_i == raddr_b_i)) begin
            rd_b_c = wdata_i;
        end
    end

    // Registered, output-enable gated read ports.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            data_a_o <= '0;
            data_b_o <= '0;
        end else begin
            data_a_o <= OE_a_i ? rd_a_c : '0;
            data_b_o <= OE_b_i ? rd_b_c : '0;
        end
    end

endmodule
